// File: rtl/radiant_scaler_count.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// radiant_scaler_count
// Per-channel saturating hit scalers, gated by PPS, internal period or manual
// strobe. Totals are latched into a Wishbone-readable shadow bank.
// Revision: 1.0
// ============================================================================
module radiant_scaler_count #(
  parameter int                    NUM_CH         = 24,
  parameter int                    SCAL_WIDTH     = 16,
  parameter int                    PERIOD_WIDTH   = 27,
  parameter logic [PERIOD_WIDTH-1:0] PERIOD_DEFAULT = 27'd49999999
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NUM_CH-1:0] scal_i,
  input  logic              pps_i,
  input  logic              wb_cyc_i,
  input  logic              wb_stb_i,
  input  logic              wb_we_i,
  input  logic [7:0]        wb_adr_i,
  input  logic [31:0]       wb_dat_i,
  input  logic [3:0]        wb_sel_i,
  output logic              wb_ack_o,
  output logic              wb_err_o,
  output logic              wb_rty_o,
  output logic [31:0]       wb_dat_o,
  output logic              update_o
);

  localparam int                    NPAIR       = NUM_CH / 2;
  localparam logic [SCAL_WIDTH-1:0] SAT_MAX     = '1;
  localparam logic [5:0]            ADR_CTRL    = 6'h00;
  localparam logic [5:0]            ADR_PERIOD  = 6'h01;
  localparam logic [5:0]            ADR_GATECNT = 6'h02;
  localparam logic [5:0]            ADR_STATUS  = 6'h03;
  localparam logic [5:0]            ADR_SHADOW  = 6'h10;

  logic [SCAL_WIDTH-1:0]   acc_q    [NUM_CH];
  logic [SCAL_WIDTH-1:0]   shadow_q [NUM_CH];
  logic [31:0]             pair_w   [NPAIR];

  logic [PERIOD_WIDTH-1:0] period_q;
  logic [PERIOD_WIDTH-1:0] pcnt_q;
  logic                    sel_q;
  logic [1:0]              man_q;
  logic [31:0]             gatecnt_q;
  logic                    status_q;
  logic                    update_q;
  logic                    ack_q;
  logic [31:0]             dat_q;
  logic [31:0]             rdata_d;

  logic [5:0] widx_w;
  logic       req_w;
  logic       wr_ctrl_w;
  logic       wr_period_w;
  logic       wr_status_w;
  logic       int_tc_w;
  logic       gate_w;
  logic       unused_w;

  assign widx_w      = wb_adr_i[7:2];
  assign req_w       = wb_cyc_i & wb_stb_i & ~ack_q;
  assign wr_ctrl_w   = req_w & wb_we_i & (widx_w == ADR_CTRL);
  assign wr_period_w = req_w & wb_we_i & (widx_w == ADR_PERIOD);
  assign wr_status_w = req_w & wb_we_i & (widx_w == ADR_STATUS);
  assign unused_w    = ^{wb_sel_i, wb_adr_i[1:0], wb_dat_i};

  assign int_tc_w = (period_q != '0) && (pcnt_q == period_q);
  // Manual gate fires two cycles after the write edge, i.e. the cycle after the ack.
  assign gate_w   = (sel_q ? int_tc_w : pps_i) | man_q[1];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      period_q <= PERIOD_DEFAULT;
      pcnt_q   <= '0;
      sel_q    <= 1'b0;
      man_q    <= 2'b00;
    end else begin
      man_q <= {man_q[0], wr_ctrl_w & wb_dat_i[1]};
      if (wr_ctrl_w) sel_q <= wb_dat_i[0];
      if (wr_period_w) begin
        period_q <= wb_dat_i[PERIOD_WIDTH-1:0];
        pcnt_q   <= '0;
      end else if ((period_q == '0) || int_tc_w) begin
        pcnt_q <= '0;
      end else begin
        pcnt_q <= pcnt_q + PERIOD_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      gatecnt_q <= '0;
      status_q  <= 1'b0;
      update_q  <= 1'b0;
    end else begin
      update_q <= gate_w;
      if (gate_w) gatecnt_q <= gatecnt_q + 32'd1;
      // A gate coinciding with a write-1-to-clear keeps the sticky bit set.
      if (gate_w)                          status_q <= 1'b1;
      else if (wr_status_w && wb_dat_i[0]) status_q <= 1'b0;
    end
  end

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    logic [SCAL_WIDTH-1:0] inc_w;
    assign inc_w = (scal_i[ch] && (acc_q[ch] != SAT_MAX)) ? acc_q[ch] + SCAL_WIDTH'(1)
                                                          : acc_q[ch];
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        acc_q[ch]    <= '0;
        shadow_q[ch] <= '0;
      end else if (gate_w) begin
        shadow_q[ch] <= inc_w;
        acc_q[ch]    <= '0;
      end else begin
        acc_q[ch] <= inc_w;
      end
    end
  end

  for (genvar k = 0; k < NPAIR; k++) begin : g_pair
    assign pair_w[k] = {16'(shadow_q[2*k+1]), 16'(shadow_q[2*k])};
  end

  always_comb begin
    rdata_d = '0;
    case (widx_w)
      ADR_CTRL:    rdata_d = {31'd0, sel_q};
      ADR_PERIOD:  rdata_d = 32'(period_q);
      ADR_GATECNT: rdata_d = gatecnt_q;
      ADR_STATUS:  rdata_d = {31'd0, status_q};
      default: begin
        for (int k = 0; k < NPAIR; k++) begin
          if (widx_w == ADR_SHADOW + 6'(k)) rdata_d = pair_w[k];
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ack_q <= 1'b0;
      dat_q <= '0;
    end else begin
      ack_q <= req_w;
      if (req_w) dat_q <= rdata_d;
    end
  end

  assign wb_ack_o = ack_q;
  assign wb_dat_o = dat_q;
  assign wb_err_o = 1'b0;
  assign wb_rty_o = 1'b0;
  assign update_o = update_q;

endmodule
`default_nettype wire
